// File: rtl/operand_fetch_regfile_pkg.sv
// operand_fetch_regfile_pkg: shared sizes, sequencer states and shift codes
package operand_fetch_regfile_pkg;
  localparam int WIDTH_D = 16;
  localparam int NREGS_D = 8;
  localparam int RIDX_D = 3;
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RD_A  = 2'd1,
    S_RD_B  = 2'd2,
    S_VALID = 2'd3
  } state_t;
  localparam logic [1:0] SH_NONE = 2'b00;
  localparam logic [1:0] SH_LSL = 2'b01;
  localparam logic [1:0] SH_LSR = 2'b10;
  localparam logic [1:0] SH_ASR = 2'b11;
endpackage

// File: rtl/operand_fetch_regfile_regfile_8x16.sv
// regfile_8x16: register storage with one synchronous write and one combinational read port
module regfile_8x16
  import operand_fetch_regfile_pkg::*;
#(
  parameter int WIDTH = WIDTH_D,
  parameter int NREGS = NREGS_D,
  parameter int RIDX = RIDX_D
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             write,
  input  logic [RIDX-1:0]  writenum,
  input  logic [WIDTH-1:0] data_in,
  input  logic [RIDX-1:0]  rsel,
  output logic [WIDTH-1:0] rdata
);
  logic [WIDTH-1:0] regs [NREGS];
  always_ff @(posedge clk) begin
    if (reset) regs <= '{default: '0};
    else if (write) regs[writenum] <= data_in;
  end
  assign rdata = regs[rsel];
endmodule

// File: rtl/operand_fetch_regfile.sv
// operand_fetch_regfile: register file plus sequencer fetching an A/B operand bundle
module operand_fetch_regfile
  import operand_fetch_regfile_pkg::*;
#(
  parameter int WIDTH = WIDTH_D,
  parameter int NREGS = NREGS_D,
  parameter int RIDX = RIDX_D
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             write,
  input  logic [RIDX-1:0]  writenum,
  input  logic [WIDTH-1:0] data_in,
  input  logic             start,
  input  logic [RIDX-1:0]  rn,
  input  logic [RIDX-1:0]  rm,
  input  logic [1:0]       shift_in,
  input  logic             opnd_ack,
  output logic             busy,
  output logic             opnd_valid,
  output logic [WIDTH-1:0] A_out,
  output logic [WIDTH-1:0] B_out,
  output logic [1:0]       shift_out
);
  state_t state, state_n;
  logic [RIDX-1:0] rn_q, rm_q, rsel;
  logic [WIDTH-1:0] rdata;
  logic accept;
  regfile_8x16 #(.WIDTH(WIDTH), .NREGS(NREGS), .RIDX(RIDX)) u_rf (
    .clk(clk), .reset(reset), .write(write), .writenum(writenum),
    .data_in(data_in), .rsel(rsel), .rdata(rdata)
  );
  always_comb begin
    accept = start && (state == S_IDLE || (state == S_VALID && opnd_ack));
    state_n = accept ? S_RD_A :
              state == S_RD_A ? S_RD_B :
              state == S_RD_B ? S_VALID :
              (state == S_VALID && opnd_ack) ? S_IDLE : state;
    rsel = state == S_RD_B ? rm_q : rn_q;
    busy = state != S_IDLE;
    opnd_valid = state == S_VALID;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      rn_q <= '0;
      rm_q <= '0;
      shift_out <= '0;
      A_out <= '0;
      B_out <= '0;
    end else begin
      state <= state_n;
      if (accept) {rn_q, rm_q, shift_out} <= {rn, rm, shift_in};
      if (state == S_RD_A) A_out <= rdata;
      if (state == S_RD_B) B_out <= rdata;
    end
  end
endmodule

// File: tb/tb_operand_fetch_regfile.sv
// tb_operand_fetch_regfile: scoreboard bench for the operand fetch sequencer
module tb_operand_fetch_regfile;
  typedef struct packed {
    logic [15:0] a;
    logic [15:0] b;
    logic [1:0]  sh;
  } bundle_t;
  logic clk = 0, reset = 1, write = 0, start = 0, opnd_ack = 0;
  logic [2:0] writenum = 0, rn = 0, rm = 0;
  logic [15:0] data_in = 0;
  logic [1:0] shift_in = 0;
  logic busy, opnd_valid;
  logic [15:0] A_out, B_out;
  logic [1:0] shift_out;
  logic [15:0] m_regs [8];
  bundle_t sbq [$];
  bundle_t last;
  int nchk = 0, nerr = 0;
  operand_fetch_regfile dut (
    .clk(clk), .reset(reset), .write(write), .writenum(writenum),
    .data_in(data_in), .start(start), .rn(rn), .rm(rm), .shift_in(shift_in),
    .opnd_ack(opnd_ack), .busy(busy), .opnd_valid(opnd_valid),
    .A_out(A_out), .B_out(B_out), .shift_out(shift_out)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(negedge clk);
  endtask
  task automatic wr(input logic [2:0] idx, input logic [15:0] val);
    write = 1;
    writenum = idx;
    data_in = val;
    step();
    write = 0;
    m_regs[idx] = val;
  endtask
  task automatic issue(input logic [2:0] a, input logic [2:0] b, input logic [1:0] sh);
    start = 1;
    rn = a;
    rm = b;
    shift_in = sh;
    sbq.push_back({m_regs[a], m_regs[b], sh});
    step();
    start = 0;
  endtask
  task automatic expect_valid(input int n0);
    int n = n0;
    while (!opnd_valid && n < 12) begin
      step();
      n++;
    end
    chk("latency", n, 3);
    if (sbq.size() == 0) begin
      chk("sb_empty", 1, 0);
    end else begin
      last = sbq.pop_front();
      chk("A_out", A_out, last.a);
      chk("B_out", B_out, last.b);
      chk("shift_out", shift_out, last.sh);
    end
  endtask
  task automatic ack();
    opnd_ack = 1;
    step();
    opnd_ack = 0;
    chk("idle_after_ack", busy, 0);
  endtask
  task automatic chk_cleared(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_valid"}, opnd_valid, 0);
    chk({tag, "_out"}, {A_out, B_out, shift_out}, 0);
  endtask
  task automatic clear_model();
    for (int i = 0; i < 8; i++) m_regs[i] = 0;
    sbq.delete();
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    clear_model();
    step();
    step();
    reset = 0;
    chk_cleared("por");
    // random prior state, then reset while busy
    for (int i = 0; i < 8; i++) wr(i[2:0], 16'($urandom));
    issue(3'($urandom_range(7)), 3'($urandom_range(7)), 2'($urandom_range(3)));
    reset = 1;
    step();
    reset = 0;
    clear_model();
    chk_cleared("rst");
    for (int i = 0; i < 4; i++) begin
      issue(3'(2 * i), 3'(2 * i + 1), 2'(i));
      expect_valid(1);
      ack();
    end
    // basic fetch with hold
    wr(2, 16'h1234);
    wr(5, 16'hF00F);
    issue(2, 5, 2'b11);
    chk("rd_a_valid", opnd_valid, 0);
    chk("rd_a_busy", busy, 1);
    expect_valid(1);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("hold", {opnd_valid, A_out, B_out, shift_out}, {1'b1, last.a, last.b, last.sh});
    end
    // back-to-back accept in VALID
    opnd_ack = 1;
    issue(5, 2, 2'b01);
    opnd_ack = 0;
    chk("b2b_valid", opnd_valid, 0);
    chk("b2b_busy", busy, 1);
    expect_valid(1);
    ack();
    // write to R5 during RD_A: A gets old value, B sees the new one
    wr(5, 16'hAAAA);
    start = 1;
    rn = 5;
    rm = 5;
    shift_in = 2'b10;
    sbq.push_back({16'hAAAA, 16'h0001, 2'b10});
    step();
    start = 0;
    wr(5, 16'h0001);
    expect_valid(2);
    ack();
    // start during RD_B is dropped
    wr(7, 16'h7777);
    issue(2, 2, 2'b00);
    step();
    start = 1;
    rn = 7;
    rm = 7;
    shift_in = 2'b11;
    step();
    start = 0;
    expect_valid(3);
    ack();
    step();
    chk("no_queue_busy", busy, 0);
    // ack while idle
    opnd_ack = 1;
    step();
    opnd_ack = 0;
    chk("ack_idle_busy", busy, 0);
    chk("ack_idle_valid", opnd_valid, 0);
    // reset during RD_B
    issue(2, 5, 2'b11);
    step();
    chk("pre_rst_busy", busy, 1);
    reset = 1;
    step();
    reset = 0;
    clear_model();
    chk_cleared("mid_rst");
    issue(2, 5, 2'b01);
    expect_valid(1);
    ack();
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
